// File: rtl/pixel_readout_receiver.sv
// Receiver for the pixel array readout bus: strobe edge detect, word FIFO with
// lane-0 coordinates, and per-pixel valid/ready unpacking with frame markers.
module pixel_readout_receiver #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int FIFO_DEPTH             = 4,
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                                        SYSTEM_CLK,
  input  logic                                        SYSTEM_RESET,
  input  logic                                        DATA_OUT_CLK,
  input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
  input  logic                                        SOFT_CLEAR,
  input  logic                                        PIXEL_READY,
  output logic                                        PIXEL_VALID,
  output logic [BIT_DEPTH-1:0]                        PIXEL_DATA,
  output logic [XW-1:0]                               PIXEL_X,
  output logic [YW-1:0]                               PIXEL_Y,
  output logic                                        FIRST_PIXEL,
  output logic                                        LAST_PIXEL,
  output logic                                        FRAME_DONE,
  output logic [15:0]                                 FRAME_COUNT,
  output logic                                        OVERFLOW
);

  localparam int OBPW = OUTPUT_BUS_PIXEL_WIDTH;
  localparam int DW   = OBPW * BIT_DEPTH;
  localparam int LW   = (OBPW > 1) ? $clog2(OBPW) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);

  localparam logic [XW-1:0] WX_LAST   = XW'(WIDTH - OBPW);
  localparam logic [YW-1:0] WY_LAST   = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(OBPW - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

  logic          clk_q;
  logic          rise;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic [15:0]   frame_count;
  logic          overflow;
  logic          frame_done;

  logic [DW-1:0] mem_word [FIFO_DEPTH];
  logic [XW-1:0] mem_wx   [FIFO_DEPTH];
  logic [YW-1:0] mem_wy   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [LW-1:0] lane;

  logic                 fifo_valid;
  logic                 fifo_full;
  logic                 hs;
  logic                 pop;
  logic                 push;
  logic [DW-1:0]        head_word;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic [BIT_DEPTH-1:0] pix_data;
  logic                 pix_first;
  logic                 pix_last;

  always_comb begin
    rise       = DATA_OUT_CLK & ~clk_q;
    fifo_valid = (count != '0);
    fifo_full  = (count == FULL_CNT);
    hs         = fifo_valid & PIXEL_READY;
    pop        = hs & (lane == LANE_LAST);
    // A pop in the same cycle frees a slot for the incoming word.
    push       = rise & ~SOFT_CLEAR & (~fifo_full | pop);
    head_word  = mem_word[rd_ptr];
    pix_x      = mem_wx[rd_ptr] + XW'(lane);
    pix_y      = mem_wy[rd_ptr];
    pix_data   = head_word[int'(lane)*BIT_DEPTH +: BIT_DEPTH];
    pix_first  = fifo_valid & (pix_x == '0) & (pix_y == '0);
    pix_last   = fifo_valid & (pix_x == X_LAST) & (pix_y == WY_LAST);
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (push) begin
      mem_word[wr_ptr] <= DATA_OUT;
      mem_wx[wr_ptr]   <= wx;
      mem_wy[wr_ptr]   <= wy;
    end
  end

  always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      clk_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      lane        <= '0;
      wx          <= '0;
      wy          <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      clk_q <= DATA_OUT_CLK;
      if (SOFT_CLEAR) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        lane       <= '0;
        wx         <= '0;
        wy         <= '0;
        overflow   <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        frame_done <= hs & pix_last;
        if (hs) lane <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        if (rise && !push) overflow <= 1'b1;
        // Coordinates advance on dropped words too, staying aligned with the sensor.
        if (rise) begin
          if (wx == WX_LAST) begin
            wx <= '0;
            if (wy == WY_LAST) begin
              wy          <= '0;
              frame_count <= frame_count + 1'b1;
            end else begin
              wy <= wy + 1'b1;
            end
          end else begin
            wx <= wx + XW'(OBPW);
          end
        end
      end
    end
  end

  always_comb begin
    PIXEL_VALID = fifo_valid;
    PIXEL_DATA  = fifo_valid ? pix_data : '0;
    PIXEL_X     = fifo_valid ? pix_x : '0;
    PIXEL_Y     = fifo_valid ? pix_y : '0;
    FIRST_PIXEL = pix_first;
    LAST_PIXEL  = pix_last;
    FRAME_DONE  = frame_done;
    FRAME_COUNT = frame_count;
    OVERFLOW    = overflow;
  end

endmodule

// File: doc/pixel_readout_receiver.md
Name: pixel_readout_receiver

Overview:
- Receiving end of the pixel array readout bus (DATA_OUT_CLK / DATA_OUT).
- Detects DATA_OUT_CLK rising edges in the SYSTEM_CLK domain and buffers each packed bus word in a FIFO.
- Unpacks each word into single pixels and presents them on a valid/ready stream, tagged with X/Y coordinates and frame markers.
- Sits between PIXEL_TOP's output bus and downstream image processing or host logic.

Parameters:
- WIDTH, 2: pixel columns per frame. WIDTH % OUTPUT_BUS_PIXEL_WIDTH must be 0.
- HEIGHT, 2: pixel rows per frame.
- OUTPUT_BUS_PIXEL_WIDTH, 2: pixels per bus word.
- BIT_DEPTH, 8: bits per pixel.
- FIFO_DEPTH, 4: bus words buffered. Power of two, at least 2.

Ports:
- SYSTEM_CLK  in  1  sole clock.
- SYSTEM_RESET  in  1  asynchronous, active-high reset.
- DATA_OUT_CLK  in  1  word strobe from the pixel array. Generated synchronously to SYSTEM_CLK.
- DATA_OUT  in  OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH  packed pixel word. Lane 0 = bits [BIT_DEPTH-1:0] = leftmost pixel.
- SOFT_CLEAR  in  1  synchronous flush and resynchronise.
- PIXEL_READY  in  1  downstream accepts a pixel.
- PIXEL_VALID  out  1  pixel available.
- PIXEL_DATA  out  BIT_DEPTH  pixel value.
- PIXEL_X  out  XW=max(1,clog2(WIDTH))  column.
- PIXEL_Y  out  YW=max(1,clog2(HEIGHT))  row.
- FIRST_PIXEL  out  1  pixel (0,0).
- LAST_PIXEL  out  1  pixel (WIDTH-1,HEIGHT-1).
- FRAME_DONE  out  1  one-cycle pulse.
- FRAME_COUNT  out  16  frames received.
- OVERFLOW  out  1  sticky: a word was dropped.

Behaviour:
- Reset (async, SYSTEM_RESET=1): FIFO empty, all counters 0, strobe history register 0.
  - Outputs: PIXEL_VALID=0, FRAME_DONE=0, FRAME_COUNT=0, OVERFLOW=0.
  - PIXEL_DATA, PIXEL_X, PIXEL_Y, FIRST_PIXEL and LAST_PIXEL are forced to 0 whenever PIXEL_VALID=0.
- Edge detect: clk_q <= DATA_OUT_CLK each cycle; rise = DATA_OUT_CLK & ~clk_q.
  - On rise, DATA_OUT is sampled in that same cycle.
  - A strobe held high for N cycles yields exactly one capture.
- Write side: counters wx (steps of OUTPUT_BUS_PIXEL_WIDTH) and wy track lane-0 coordinates.
  - On rise the FIFO stores {word, wx, wy}.
  - wx wraps at WIDTH and increments wy. wy wraps at HEIGHT.
  - On wrap of the last word of a frame, FRAME_COUNT increments (wraps at 2^16).
  - Counters advance on every rise, including dropped words, so coordinates stay aligned with the sensor.
- Full: a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and OVERFLOW is set to 1. OVERFLOW clears only on reset or SOFT_CLEAR.
- Read side: a lane counter selects a pixel from the FIFO head.
  - PIXEL_VALID = FIFO not empty.
  - PIXEL_X = head.wx + lane; PIXEL_Y = head.wy.
  - Handshake when PIXEL_VALID & PIXEL_READY: lane increments. On the last lane, lane returns to 0 and the head is popped.
  - All outputs hold stable while PIXEL_VALID=1 and PIXEL_READY=0.
- Latency: a word captured at cycle t (rise seen) presents lane 0 at cycle t+1 if the FIFO was empty. No combinational path from DATA_OUT to outputs.
- FIRST_PIXEL and LAST_PIXEL are combinational from the head coordinates.
- FRAME_DONE pulses in the cycle after the handshake of a LAST_PIXEL pixel.
- SOFT_CLEAR (synchronous, highest priority):
  - Empties the FIFO, zeroes lane, wx, wy and OVERFLOW. FRAME_COUNT is kept.
  - A rise in the same cycle is discarded.
- Reset mid-frame: all state is lost. The next captured word is treated as (0,0).

Test Plan (defaults unless stated):
- READY=1; strobe DATA_OUT=16'hBBAA then 16'hDDCC -> pixels AA(0,0,FIRST), BB(1,0), CC(0,1), DD(1,1,LAST). FRAME_DONE pulses once; FRAME_COUNT=1; first PIXEL_VALID one cycle after the first rise.
- READY=0; 5 strobes of 16'h0101..16'h0505 -> words 1–4 stored, OVERFLOW=1. After releasing READY, output is 01,01,02,02,03,03,04,04 with coordinates (0,0),(1,0),(0,1),(1,1),(0,0),(1,0),(0,1),(1,1); FRAME_COUNT=2.
- DATA_OUT_CLK held high 5 cycles with DATA_OUT changing -> exactly one word captured (the value at the rising cycle).
- FIFO full, READY=1 on the last lane in the same cycle as a rise -> the new word is accepted, OVERFLOW stays 0.
- SOFT_CLEAR after the first word of a frame, in the same cycle as a rise -> FIFO empty, PIXEL_VALID=0, OVERFLOW=0; the next word is tagged (0,0) with FIRST_PIXEL=1.
- SYSTEM_RESET pulsed asynchronously mid-frame while PIXEL_VALID=1 -> all outputs 0 immediately; FRAME_COUNT=0; after release, the next word starts at (0,0).
